// File: rtl/scroll_sequencer_pkg.sv
// Shared types and helpers for the scroll sequencer.
//   scrolling_t     latched scroll request (direction, step, margins, clear)
//   scroll_state_e  sequencer FSM states
//   is_copy_line    decides COPY versus FILL for one destination line
package scroll_sequencer_pkg;

  localparam int unsigned CONSOLE_COLUMNS = 80;
  localparam int unsigned CONSOLE_LINES   = 24;
  localparam int unsigned LINE_W          = 8;
  localparam logic [15:0] BLANK_CELL      = 16'h0720;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COPY,
    ST_FILL,
    ST_REJECT,
    ST_DONE
  } scroll_state_e;

  typedef struct packed {
    logic              dir;
    logic [LINE_W-1:0] step;
    logic [LINE_W-1:0] top;
    logic [LINE_W-1:0] bottom;
    logic              clear;
  } scrolling_t;

  // A zero step still scrolls by one line.
  function automatic logic [LINE_W-1:0] eff_step(input logic [LINE_W-1:0] step);
    return (step == '0) ? LINE_W'(1) : step;
  endfunction

  // Compares are done in LINE_W+1 bits so top+step or dst+step cannot wrap.
  function automatic logic is_copy_line(input logic [LINE_W-1:0] dst,
                                        input logic [LINE_W-1:0] step,
                                        input logic [LINE_W-1:0] top,
                                        input logic [LINE_W-1:0] bottom,
                                        input logic              down,
                                        input logic              clear);
    logic [LINE_W:0] w_dst;
    logic [LINE_W:0] w_step;
    w_dst  = {1'b0, dst};
    w_step = {1'b0, step};
    if (clear) begin
      return 1'b0;
    end
    if (down) begin
      return w_dst >= ({1'b0, top} + w_step);
    end
    return (w_dst + w_step) <= {1'b0, bottom};
  endfunction

endpackage

// File: rtl/scroll_addr_gen.sv
// Line/column address generator for the scroll sequencer.
//   i_start      load first-line bases (accepted legal request)
//   i_next_line  step both line bases by one line (i_down selects direction)
//   i_copy       current cycle belongs to a COPY line
//   i_active_nxt next cycle is a COPY or FILL cycle; i_copy_nxt: it is COPY
//   o_last_col_c current cycle is the last one of its line
//   o_raddr / o_waddr / o_we / o_wsel_copy  registered RAM controls
module scroll_addr_gen
  import scroll_sequencer_pkg::*;
#(
  parameter int unsigned COLUMNS = CONSOLE_COLUMNS,
  parameter int unsigned AW      = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_dst_base0,
  input  logic [AW-1:0] i_src_base0,
  input  logic          i_next_line,
  input  logic          i_down,
  input  logic          i_copy,
  input  logic          i_active_nxt,
  input  logic          i_copy_nxt,
  output logic          o_last_col_c,
  output logic [AW-1:0] o_raddr,
  output logic [AW-1:0] o_waddr,
  output logic          o_we,
  output logic          o_wsel_copy
);

  localparam int unsigned   CW            = $clog2(COLUMNS + 1);
  localparam logic [AW-1:0] LINE_STRIDE   = AW'(COLUMNS);
  localparam logic [CW-1:0] COL_LAST_COPY = CW'(COLUMNS);
  localparam logic [CW-1:0] COL_LAST_FILL = CW'(COLUMNS - 1);

  logic [CW-1:0] r_col;
  logic [AW-1:0] r_dst_base;
  logic [AW-1:0] r_src_base;
  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_waddr;
  logic          r_we;
  logic          r_wsel_copy;

  logic [CW-1:0] w_col_nxt;
  logic [AW-1:0] w_dst_base_nxt;
  logic [AW-1:0] w_src_base_nxt;
  logic          w_we_nxt;
  logic          w_rd_nxt;
  logic [AW-1:0] w_raddr_nxt;
  logic [AW-1:0] w_waddr_nxt;

  // COPY spans COLUMNS+1 cycles (write trails read by one), FILL spans COLUMNS.
  assign o_last_col_c = i_copy ? (r_col == COL_LAST_COPY) : (r_col == COL_LAST_FILL);

  // Running line bases and column counter for the coming cycle.
  always_comb begin
    w_col_nxt      = r_col;
    w_dst_base_nxt = r_dst_base;
    w_src_base_nxt = r_src_base;
    if (i_start) begin
      w_col_nxt      = '0;
      w_dst_base_nxt = i_dst_base0;
      w_src_base_nxt = i_src_base0;
    end else if (i_next_line) begin
      w_col_nxt      = '0;
      w_dst_base_nxt = i_down ? (r_dst_base - LINE_STRIDE) : (r_dst_base + LINE_STRIDE);
      w_src_base_nxt = i_down ? (r_src_base - LINE_STRIDE) : (r_src_base + LINE_STRIDE);
    end else if (i_active_nxt) begin
      w_col_nxt = r_col + CW'(1);
    end
  end

  // RAM controls for the coming cycle; a COPY writes column k-1 while reading column k.
  always_comb begin
    w_we_nxt    = i_active_nxt & (~i_copy_nxt | (w_col_nxt != '0));
    w_rd_nxt    = i_copy_nxt & (w_col_nxt != COL_LAST_COPY);
    w_raddr_nxt = w_src_base_nxt + AW'(w_col_nxt);
    w_waddr_nxt = w_dst_base_nxt + AW'(w_col_nxt) - AW'(i_copy_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_dst_base  <= '0;
      r_src_base  <= '0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_we        <= 1'b0;
      r_wsel_copy <= 1'b0;
    end else begin
      r_col       <= w_col_nxt;
      r_dst_base  <= w_dst_base_nxt;
      r_src_base  <= w_src_base_nxt;
      r_we        <= w_we_nxt;
      r_wsel_copy <= w_we_nxt & i_copy_nxt;
      if (w_rd_nxt) begin
        r_raddr <= w_raddr_nxt;
      end
      if (w_we_nxt) begin
        r_waddr <= w_waddr_nxt;
      end
    end
  end

  assign o_raddr     = r_raddr;
  assign o_waddr     = r_waddr;
  assign o_we        = r_we;
  assign o_wsel_copy = r_wsel_copy;

endmodule

// File: rtl/scroll_sequencer.sv
// Scroll sequencer: turns one scroll/clear request into line COPY/FILL traffic
// on the text-buffer RAM, one cell per cycle.
//   req_*      request handshake and fields (latched on req_valid & req_ready)
//   busy/done  busy from acceptance through the done pulse
//   ram_*      read port (1-cycle latency) and write port of the text buffer
module scroll_sequencer
  import scroll_sequencer_pkg::*;
#(
  parameter int unsigned       COLUMNS = CONSOLE_COLUMNS,
  parameter int unsigned       LINES   = CONSOLE_LINES,
  parameter int unsigned       CELL_W  = 16,
  parameter logic [CELL_W-1:0] BLANK   = CELL_W'(BLANK_CELL),
  localparam int unsigned      AW      = $clog2(COLUMNS * LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [7:0]        req_step,
  input  logic [7:0]        req_top,
  input  logic [7:0]        req_bottom,
  input  logic              req_clear,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     ram_raddr,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_waddr,
  output logic [CELL_W-1:0] ram_wdata
);

  localparam logic [AW-1:0] LINE_STRIDE = AW'(COLUMNS);

  scroll_state_e     r_state;
  scroll_state_e     w_state_nxt;
  scrolling_t        r_req;
  logic [LINE_W-1:0] r_dst;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_start;
  logic              w_next_line;
  logic [LINE_W-1:0] w_in_step;
  logic              w_in_down;
  logic              w_in_illegal;
  logic [LINE_W-1:0] w_in_dst;
  logic [LINE_W-1:0] w_in_src;
  logic              w_in_copy;
  logic [AW-1:0]     w_dst_base0;
  logic [AW-1:0]     w_src_base0;
  logic              w_down;
  logic              w_last_line;
  logic [LINE_W-1:0] w_dst_adv;
  logic              w_adv_copy;
  logic              w_last_col;
  logic              w_active_nxt;
  logic              w_copy_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_wsel_copy;

  // Decode of the request at the acceptance edge.
  always_comb begin
    w_accept     = (r_state == ST_IDLE) & req_valid;
    w_in_step    = eff_step(req_step);
    w_in_down    = req_dir & ~req_clear;
    w_in_illegal = (req_top > req_bottom) || ({1'b0, req_bottom} >= (LINE_W + 1)'(LINES));
    w_start      = w_accept & ~w_in_illegal;
    w_in_dst     = w_in_down ? req_bottom : req_top;
    w_in_src     = w_in_down ? (req_bottom - w_in_step) : (req_top + w_in_step);
    w_in_copy    = is_copy_line(w_in_dst, w_in_step, req_top, req_bottom, w_in_down, req_clear);
    // Constant-coefficient product, needed once so the first RAM cycle has no bubble.
    w_dst_base0  = AW'(w_in_dst) * LINE_STRIDE;
    w_src_base0  = AW'(w_in_src) * LINE_STRIDE;
  end

  // Progress through the margin region with the latched request.
  always_comb begin
    w_down      = r_req.dir & ~r_req.clear;
    w_last_line = w_down ? (r_dst == r_req.top) : (r_dst == r_req.bottom);
    w_dst_adv   = w_down ? (r_dst - LINE_W'(1)) : (r_dst + LINE_W'(1));
    w_adv_copy  = is_copy_line(w_dst_adv, r_req.step, r_req.top, r_req.bottom, w_down, r_req.clear);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; the per-line COPY/FILL choice is folded into the line transition.
  always_comb begin
    w_state_nxt = r_state;
    w_next_line = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_in_illegal) begin
            w_state_nxt = ST_REJECT;
          end else begin
            w_state_nxt = w_in_copy ? ST_COPY : ST_FILL;
          end
        end
      end
      ST_COPY, ST_FILL: begin
        if (w_last_col) begin
          if (w_last_line) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_next_line = 1'b1;
            w_state_nxt = w_adv_copy ? ST_COPY : ST_FILL;
          end
        end
      end
      ST_REJECT: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs for the coming cycle.
  always_comb begin
    w_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_done_nxt   = (w_state_nxt == ST_DONE);
    w_copy_nxt   = (w_state_nxt == ST_COPY);
    w_active_nxt = (w_state_nxt == ST_COPY) || (w_state_nxt == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_req_ready <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Request latch and current destination line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
      r_dst <= '0;
    end else if (w_accept) begin
      r_req <= '{dir: req_dir, step: w_in_step, top: req_top, bottom: req_bottom, clear: req_clear};
      r_dst <= w_in_dst;
    end else if (w_next_line) begin
      r_dst <= w_dst_adv;
    end
  end

  scroll_addr_gen #(
    .COLUMNS (COLUMNS),
    .AW      (AW)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_dst_base0  (w_dst_base0),
    .i_src_base0  (w_src_base0),
    .i_next_line  (w_next_line),
    .i_down       (w_down),
    .i_copy       (r_state == ST_COPY),
    .i_active_nxt (w_active_nxt),
    .i_copy_nxt   (w_copy_nxt),
    .o_last_col_c (w_last_col),
    .o_raddr      (ram_raddr),
    .o_waddr      (ram_waddr),
    .o_we         (ram_we),
    .o_wsel_copy  (w_wsel_copy)
  );

  // The RAM read register is the read-to-write stage, so copy data passes straight through.
  assign ram_wdata = w_wsel_copy ? ram_rdata : BLANK;
  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_scroll_sequencer.sv
module tb_scroll_sequencer;

  localparam logic [15:0] BLANK = 16'h0720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic [7:0]  req_step = '0;
  logic [7:0]  req_top = '0;
  logic [7:0]  req_bottom = '0;
  logic        req_clear = 1'b0;
  logic        busy;
  logic        done;
  logic [3:0]  ram_raddr;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [15:0] ram_wdata;

  logic [15:0] mem [16];
  logic        load = 1'b0;
  logic [3:0]  last_raddr = '0;
  int          n_wr = 0;
  int          n_rchg = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  scroll_sequencer #(
    .COLUMNS (4),
    .LINES   (4),
    .CELL_W  (16),
    .BLANK   (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dir    (req_dir),
    .req_step   (req_step),
    .req_top    (req_top),
    .req_bottom (req_bottom),
    .req_clear  (req_clear),
    .busy       (busy),
    .done       (done),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata)
  );

  always #5 clk = ~clk;

  // Text-buffer model: registered read, write on we; preload cell = {line, col}.
  always @(posedge clk) begin
    if (load) begin
      for (int l = 0; l < 4; l++) begin
        for (int c = 0; c < 4; c++) begin
          mem[4'(l * 4 + c)] <= {8'(l), 8'(c)};
        end
      end
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
    if (ram_we) n_wr = n_wr + 1;
    if (ram_raddr !== last_raddr) n_rchg = n_rchg + 1;
    last_raddr = ram_raddr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_val(input int src);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) begin
      v[c*16 +: 16] = (src < 0) ? BLANK : {8'(src), 8'(c)};
    end
    return v;
  endfunction

  // src = original line expected in this line, -1 = all BLANK.
  task automatic chk_line(input string tag, input int line, input int src);
    logic [63:0] obs;
    for (int c = 0; c < 4; c++) begin
      obs[c*16 +: 16] = mem[4'(line * 4 + c)];
    end
    chk(tag, obs, line_val(src));
  endtask

  task automatic preload();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a negedge with req_ready high; returns at the negedge after acceptance.
  task automatic send(input logic dir, input logic [7:0] step, input logic [7:0] top,
                      input logic [7:0] bot, input logic clr);
    req_dir = dir; req_step = step; req_top = top; req_bottom = bot; req_clear = clr;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // cyc = cycles from acceptance to the done pulse; nbusy = busy cycles seen.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    if (busy === 1'b1) nbusy++;
  endtask

  task automatic chk_after(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_busy0"}, 64'(busy), 64'(0));
    chk({tag, "_done0"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc, nb, w0, r0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_we", 64'(ram_we), 64'(0));
    chk("rst_raddr", 64'(ram_raddr), 64'(0));
    chk("rst_waddr", 64'(ram_waddr), 64'(0));
    chk("rst_wdata", 64'(ram_wdata), 64'(BLANK));
    rst_n = 1'b1;
    @(negedge clk);

    // Up by 1 over the whole screen.
    preload();
    w0 = n_wr;
    send(1'b0, 8'd1, 8'd0, 8'd3, 1'b0);
    chk("up_busy_c0", 64'(busy), 64'(1));
    chk("up_ready_c0", 64'(req_ready), 64'(0));
    wait_done(cyc, nb);
    chk("up_cycles", 64'(cyc), 64'(19));
    chk("up_writes", 64'(n_wr - w0), 64'(16));
    chk_line("up_l0", 0, 1);
    chk_line("up_l1", 1, 2);
    chk_line("up_l2", 2, 3);
    chk_line("up_l3", 3, -1);
    chk_after("up");

    // Down by 2 inside margins 1..3.
    preload();
    w0 = n_wr;
    send(1'b1, 8'd2, 8'd1, 8'd3, 1'b0);
    wait_done(cyc, nb);
    chk("dn_cycles", 64'(cyc), 64'(13));
    chk("dn_writes", 64'(n_wr - w0), 64'(12));
    chk_line("dn_l0", 0, 0);
    chk_line("dn_l1", 1, -1);
    chk_line("dn_l2", 2, -1);
    chk_line("dn_l3", 3, 1);
    chk_after("dn");

    // Step 0 behaves as step 1, margins 1..2.
    preload();
    w0 = n_wr;
    send(1'b0, 8'd0, 8'd1, 8'd2, 1'b0);
    wait_done(cyc, nb);
    chk("s0_cycles", 64'(cyc), 64'(9));
    chk("s0_writes", 64'(n_wr - w0), 64'(8));
    chk_line("s0_l0", 0, 0);
    chk_line("s0_l1", 1, 2);
    chk_line("s0_l2", 2, -1);
    chk_line("s0_l3", 3, 3);

    // Step larger than the margin region: fill only, no reads.
    preload();
    w0 = n_wr;
    r0 = n_rchg;
    send(1'b0, 8'd9, 8'd0, 8'd3, 1'b0);
    wait_done(cyc, nb);
    chk("s9_cycles", 64'(cyc), 64'(16));
    chk("s9_writes", 64'(n_wr - w0), 64'(16));
    chk("s9_reads", 64'(n_rchg - r0), 64'(0));
    for (int l = 0; l < 4; l++) chk_line("s9_line", l, -1);

    // Clear margins 1..2, direction and step ignored.
    preload();
    w0 = n_wr;
    send(1'b1, 8'd1, 8'd1, 8'd2, 1'b1);
    wait_done(cyc, nb);
    chk("clr_cycles", 64'(cyc), 64'(8));
    chk("clr_writes", 64'(n_wr - w0), 64'(8));
    chk_line("clr_l0", 0, 0);
    chk_line("clr_l1", 1, -1);
    chk_line("clr_l2", 2, -1);
    chk_line("clr_l3", 3, 3);

    // Illegal: top > bottom.
    preload();
    w0 = n_wr;
    send(1'b0, 8'd1, 8'd3, 8'd1, 1'b0);
    wait_done(cyc, nb);
    chk("ill_cycles", 64'(cyc), 64'(1));
    chk("ill_busy", 64'(nb), 64'(2));
    chk("ill_writes", 64'(n_wr - w0), 64'(0));
    chk_after("ill");

    // Illegal: bottom beyond the screen.
    w0 = n_wr;
    send(1'b0, 8'd1, 8'd0, 8'd4, 1'b0);
    wait_done(cyc, nb);
    chk("ill2_cycles", 64'(cyc), 64'(1));
    chk("ill2_writes", 64'(n_wr - w0), 64'(0));
    chk_line("ill2_l3", 3, 3);
    @(negedge clk);

    // req_valid held through busy with new fields: first op unaffected, second taken after ready.
    preload();
    w0 = n_wr;
    req_dir = 1'b0; req_step = 8'd1; req_top = 8'd0; req_bottom = 8'd3; req_clear = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_dir = 1'b1; req_step = 8'd3; req_clear = 1'b1;
    wait_done(cyc, nb);
    chk("hold_cycles", 64'(cyc), 64'(19));
    chk("hold_writes", 64'(n_wr - w0), 64'(16));
    chk_line("hold_l0", 0, 1);
    chk_line("hold_l3", 3, -1);
    @(negedge clk);
    chk("hold_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    chk("hold_second", 64'(busy), 64'(1));
    req_valid = 1'b0;
    wait_done(cyc, nb);
    chk("hold2_cycles", 64'(cyc), 64'(16));
    chk_line("hold2_l0", 0, -1);
    chk_after("hold2");

    // Reset in the middle of a copy, then a fresh request.
    preload();
    send(1'b0, 8'd1, 8'd0, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_we", 64'(ram_we), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mrst_we", 64'(ram_we), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_ready", 64'(req_ready), 64'(1));
    chk("mrst_waddr", 64'(ram_waddr), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    preload();
    w0 = n_wr;
    send(1'b1, 8'd1, 8'd0, 8'd3, 1'b0);
    wait_done(cyc, nb);
    chk("post_cycles", 64'(cyc), 64'(19));
    chk("post_writes", 64'(n_wr - w0), 64'(16));
    chk_line("post_l0", 0, -1);
    chk_line("post_l1", 1, 0);
    chk_line("post_l2", 2, 1);
    chk_line("post_l3", 3, 2);
    chk_after("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
